decoder_csr_bank: RTL and testbench

DECODER_CSR_BANK -- requirements
Module: decoder_csr_bank

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_ring_ptr.sv | 61 ++++++
 rtl/decoder_csr_bank.sv | 166 ++++++++++++++++
 tb/tb_decoder_csr_bank.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and types for the decoder CSR bank.
//   CSR_RESET_VAL   reset value loaded into every CSR (sliced to the CSR width)
//   CSR_RING_BASE   CSR index holding the ring buffer base address
//   CSR_RING_END    CSR index holding the ring buffer end address (exclusive)
//   CSR_RAM0_BASE   CSR index of RAM bank 0 base address
//   CSR_RAM1_BASE   CSR index of RAM bank 1 base address
//   commit_state_e  shadow->active commit handshake states
package decoder_pkg;

  localparam logic [63:0] CSR_RESET_VAL = '0;

  localparam int unsigned CSR_RING_BASE = 0;
  localparam int unsigned CSR_RING_END  = 1;
  localparam int unsigned CSR_RAM0_BASE = 2;
  localparam int unsigned CSR_RAM1_BASE = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/decoder_ring_ptr.sv
// decoder_ring_ptr: ring buffer read pointer with wrap-around.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   reload_i        load reload_val_i into the pointer (has priority over adv_i)
//   reload_val_i    value loaded on reload
//   adv_i, step_i   advance the pointer by step_i
//   base_i, end_i   ring base and exclusive end
//   ptr_o           current pointer
//   wrap_o          one-cycle pulse after an advance that wrapped
module decoder_ring_ptr
  import decoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reload_i,
  input  logic [DATA_WIDTH-1:0] reload_val_i,
  input  logic                  adv_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic [DATA_WIDTH-1:0] base_i,
  input  logic [DATA_WIDTH-1:0] end_i,
  output logic [DATA_WIDTH-1:0] ptr_o,
  output logic                  wrap_o
);

  logic [DATA_WIDTH-1:0] ptr_q;
  logic                  wrap_q;
  logic [DATA_WIDTH:0]   sum;
  logic                  wraps;
  logic [DATA_WIDTH-1:0] wrapped;

  // Carry bit kept so a sum past 2^DATA_WIDTH still compares correctly
  // against the end address; the wrapped value is only needed modulo
  // 2^DATA_WIDTH, so the low bits suffice there.
  assign sum     = {1'b0, ptr_q} + {1'b0, step_i};
  assign wraps   = sum >= {1'b0, end_i};
  assign wrapped = base_i + sum[DATA_WIDTH-1:0] - end_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (reload_i) begin
        ptr_q <= reload_val_i;
      end else if (adv_i) begin
        if (wraps) begin
          ptr_q  <= wrapped;
          wrap_q <= 1'b1;
        end else begin
          ptr_q <= sum[DATA_WIDTH-1:0];
        end
      end
    end
  end

  assign ptr_o  = ptr_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/decoder_csr_bank.sv
// decoder_csr_bank: decoder control/status register bank with an optional
// shadow copy committed atomically to the active set, plus a ring pointer.
// Build option: DECODER_CSR_SHADOW_EN enables double buffering; without it
// writes land directly in the active set and commits only reload the pointer.
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   rf_wr_i/_idx_i/_data_i/_be_i  byte-enabled CSR write port
//   rf_rd_idx_i, rf_rd_data_o     combinational debug read of the write-side copy
//   rf_active_o                   active CSRs flattened, reg 0 in the LSBs
//   commit_i, engine_busy_i       commit request, held off while the engine is busy
//   commit_pending_o              commit waiting for engine idle
//   commit_done_o                 one-cycle pulse when the commit takes effect
//   ptr_adv_i, ptr_step_i         ring pointer advance
//   ptr_o, ptr_wrap_o             ring pointer and wrap pulse
`ifndef CORE_DATAWIDTH
`define CORE_DATAWIDTH 32
`endif

module decoder_csr_bank
  import decoder_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned DATA_WIDTH = `CORE_DATAWIDTH,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rf_wr_i,
  input  logic [IDX_WIDTH-1:0]           rf_wr_idx_i,
  input  logic [DATA_WIDTH-1:0]          rf_wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]        rf_wr_be_i,
  input  logic [IDX_WIDTH-1:0]           rf_rd_idx_i,
  output logic [DATA_WIDTH-1:0]          rf_rd_data_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] rf_active_o,
  input  logic                           commit_i,
  input  logic                           engine_busy_i,
  output logic                           commit_pending_o,
  output logic                           commit_done_o,
  input  logic                           ptr_adv_i,
  input  logic [DATA_WIDTH-1:0]          ptr_step_i,
  output logic [DATA_WIDTH-1:0]          ptr_o,
  output logic                           ptr_wrap_o
);

  localparam int unsigned           NUM_BYTES    = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] RST_VAL      = DATA_WIDTH'(CSR_RESET_VAL);
  localparam logic [IDX_WIDTH:0]    NUM_REGS_IDX = (IDX_WIDTH + 1)'(NUM_REGS);

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NUM_BYTES-1:0]  be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic                  wr_hit;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] active_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  commit_exec;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] reload_val;

  assign wr_hit = rf_wr_i && ({1'b0, rf_wr_idx_i} < NUM_REGS_IDX);
  assign rd_hit = {1'b0, rf_rd_idx_i} < NUM_REGS_IDX;

`ifdef DECODER_CSR_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  commit_state_e         state_q;
  commit_state_e         state_d;

  assign wr_merged = merge_bytes(shadow_q[rf_wr_idx_i], rf_wr_data_i, rf_wr_be_i);

  // Commit requests arriving while PEND fold into the pending one.
  always_comb begin
    state_d     = state_q;
    commit_exec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          if (engine_busy_i) state_d = ST_PEND;
          else               commit_exec = 1'b1;
        end
      end
      ST_PEND: begin
        if (!engine_busy_i) begin
          commit_exec = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The copy reads shadow_q before this edge's write, so a colliding write
  // lands in the shadow only and waits for the next commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RST_VAL;
        active_q[i] <= RST_VAL;
      end
    end else begin
      state_q <= state_d;
      done_q  <= commit_exec;
      if (commit_exec) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) active_q[i] <= shadow_q[i];
      end
      if (wr_hit) shadow_q[rf_wr_idx_i] <= wr_merged;
    end
  end

  assign rf_rd_data_o     = rd_hit ? shadow_q[rf_rd_idx_i] : '0;
  assign reload_val       = shadow_q[CSR_RING_BASE];
  assign commit_pending_o = (state_q == ST_PEND);
`else
  logic unused_busy;

  assign unused_busy = engine_busy_i;
  assign wr_merged   = merge_bytes(active_q[rf_wr_idx_i], rf_wr_data_i, rf_wr_be_i);
  assign commit_exec = commit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) active_q[i] <= RST_VAL;
    end else begin
      done_q <= commit_i;
      if (wr_hit) active_q[rf_wr_idx_i] <= wr_merged;
    end
  end

  assign rf_rd_data_o     = rd_hit ? active_q[rf_rd_idx_i] : '0;
  assign reload_val       = active_q[CSR_RING_BASE];
  assign commit_pending_o = 1'b0;
`endif

  assign commit_done_o = done_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign rf_active_o[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
  end

  decoder_ring_ptr #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ring_ptr (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .reload_i     (commit_exec),
    .reload_val_i (reload_val),
    .adv_i        (ptr_adv_i),
    .step_i       (ptr_step_i),
    .base_i       (active_q[CSR_RING_BASE]),
    .end_i        (active_q[CSR_RING_END]),
    .ptr_o        (ptr_o),
    .wrap_o       (ptr_wrap_o)
  );

endmodule

// File: tb/tb_decoder_csr_bank.sv
// Self-checking bench for decoder_csr_bank (works with DECODER_CSR_SHADOW_EN
// defined or undefined). NUM_REGS=6 leaves indices 6 and 7 out of range.
module tb_decoder_csr_bank;

  localparam int NR = 6;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int FW = NR * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rf_wr = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_be = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [DW-1:0] rd_data;
  logic [FW-1:0] active;
  logic          commit = 1'b0;
  logic          busy = 1'b0;
  logic          pending;
  logic          done;
  logic          adv = 1'b0;
  logic [DW-1:0] step = '0;
  logic [DW-1:0] ptr;
  logic          wrap;

  always #5 clk = ~clk;

  decoder_csr_bank #(
    .NUM_REGS   (NR),
    .DATA_WIDTH (DW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .rf_wr_i          (rf_wr),
    .rf_wr_idx_i      (wr_idx),
    .rf_wr_data_i     (wr_data),
    .rf_wr_be_i       (wr_be),
    .rf_rd_idx_i      (rd_idx),
    .rf_rd_data_o     (rd_data),
    .rf_active_o      (active),
    .commit_i         (commit),
    .engine_busy_i    (busy),
    .commit_pending_o (pending),
    .commit_done_o    (done),
    .ptr_adv_i        (adv),
    .ptr_step_i       (step),
    .ptr_o            (ptr),
    .ptr_wrap_o       (wrap)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  bit cnt_en   = 0;
  int pend_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register file contents, commit-pending flag and ring
  // pointer, updated per clock from the documented rules.
  logic [DW-1:0] m_sh  [NR];
  logic [DW-1:0] m_act [NR];
  logic [DW-1:0] m_ptr;
  logic          m_pend, m_done, m_wrap;

  always @(posedge clk or negedge rst_n) begin : model
    logic [DW:0] nx;
    logic        ex;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_sh[i]  = '0;
        m_act[i] = '0;
      end
      m_ptr  = '0;
      m_pend = 1'b0;
      m_done = 1'b0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
`ifdef DECODER_CSR_SHADOW_EN
      ex = (commit || m_pend) && !busy;
      if (ex) begin
        m_act  = m_sh;
        m_pend = 1'b0;
      end else if (commit) begin
        m_pend = 1'b1;
      end
`else
      ex = commit;
`endif
      if (ex) begin
        m_ptr = m_act[0];
      end else if (adv) begin
        nx = {1'b0, m_ptr} + {1'b0, step};
        if (nx >= {1'b0, m_act[1]}) begin
          m_ptr  = DW'({1'b0, m_act[0]} + nx - {1'b0, m_act[1]});
          m_wrap = 1'b1;
        end else begin
          m_ptr = nx[DW-1:0];
        end
      end
      m_done = ex;
      if (rf_wr && int'(wr_idx) < NR) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) begin
`ifdef DECODER_CSR_SHADOW_EN
            m_sh[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
`else
            m_act[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
`endif
          end
        end
      end
    end
  end

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_act[i];
    return f;
  endfunction

  function automatic logic [DW-1:0] model_rd();
    if (int'(rd_idx) >= NR) return '0;
`ifdef DECODER_CSR_SHADOW_EN
    return m_sh[rd_idx];
`else
    return m_act[rd_idx];
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("active", active, model_flat());
      check("rd_data", FW'(rd_data), FW'(model_rd()));
      check("pending", FW'(pending), FW'(m_pend));
      check("done", FW'(done), FW'(m_done));
      check("ptr", FW'(ptr), FW'(m_ptr));
      check("wrap", FW'(wrap), FW'(m_wrap));
      if (cnt_en) begin
        pend_cnt += int'(pending);
        done_cnt += int'(done);
      end
    end
  end

  task automatic wr(input int idx, input logic [DW-1:0] d, input logic [3:0] be);
    rf_wr = 1'b1; wr_idx = IW'(idx); wr_data = d; wr_be = be;
    @(posedge clk); #1;
    rf_wr = 1'b0;
  endtask

  task automatic do_commit(input logic b);
    commit = 1'b1; busy = b;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic do_adv(input logic [DW-1:0] s);
    adv = 1'b1; step = s;
    @(posedge clk); #1;
    adv = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] steps [5];
    steps[0] = 32'h4; steps[1] = 32'h3C; steps[2] = 32'h7;
    steps[3] = 32'h0; steps[4] = 32'h50;

    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    check("reset_ptr", FW'(ptr), '0);
    check("reset_active", active, '0);
    check("reset_pending", FW'(pending), '0);
    rst_n = 1'b1;

    // byte enables
    wr(2, 32'hAABBCCDD, 4'b0101);
    rd_idx = 3'd2;
    @(negedge clk);
    check("be_reg2", FW'(rd_data), FW'(32'h00BB00DD));

    // direct/shadow write visibility on the active set
    wr(1, 32'h80, 4'hF);
    @(negedge clk);
`ifdef DECODER_CSR_SHADOW_EN
    check("reg1_active_before_commit", FW'(active[DW +: DW]), '0);
`else
    check("reg1_active_direct", FW'(active[DW +: DW]), FW'(32'h80));
`endif
    check("reg1_pending", FW'(pending), '0);

    // ring setup and wrap
    wr(0, 32'h100, 4'hF);
    wr(1, 32'h140, 4'hF);
    do_commit(1'b0);
    @(negedge clk);
    check("commit_ptr_reload", FW'(ptr), FW'(32'h100));
    check("commit_done_pulse", FW'(done), FW'(1'b1));
    do_adv(32'h30);
    @(negedge clk);
    check("adv_no_wrap", FW'(ptr), FW'(32'h130));
    do_adv(32'h20);
    @(negedge clk);
    check("wrap_ptr", FW'(ptr), FW'(32'h110));
    check("wrap_pulse", FW'(wrap), FW'(1'b1));
    do_adv(32'h30);
    @(negedge clk);
    check("wrap_at_end", FW'(ptr), FW'(32'h100));

    // commit while busy, with a second request merged while pending
    wr(3, 32'h12345678, 4'hF);
    pend_cnt = 0; done_cnt = 0; cnt_en = 1;
    commit = 1'b1; busy = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
    @(posedge clk); #1 commit = 1'b1;
    @(posedge clk); #1 commit = 1'b0;
    repeat (2) @(posedge clk);
    #1 busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 cnt_en = 0;
`ifdef DECODER_CSR_SHADOW_EN
    check("busy_pending_cycles", FW'(pend_cnt), FW'(5));
    check("busy_done_pulses", FW'(done_cnt), FW'(1));
`else
    check("busy_pending_cycles", FW'(pend_cnt), FW'(0));
    check("busy_done_pulses", FW'(done_cnt), FW'(2));
`endif
    check("busy_reg3_active", FW'(active[3*DW +: DW]), FW'(32'h12345678));

    // same-cycle write/commit/advance collision
    wr(0, 32'h180, 4'hF);
    commit = 1'b1; busy = 1'b0;
    rf_wr = 1'b1; wr_idx = 3'd0; wr_data = 32'h200; wr_be = 4'hF;
    adv = 1'b1; step = 32'h4;
    @(posedge clk); #1;
    commit = 1'b0; rf_wr = 1'b0; adv = 1'b0;
    rd_idx = 3'd0;
    @(negedge clk);
    check("collide_ptr", FW'(ptr), FW'(32'h180));
    check("collide_wrap", FW'(wrap), '0);
    check("collide_rd0", FW'(rd_data), FW'(32'h200));
`ifdef DECODER_CSR_SHADOW_EN
    check("collide_active0", FW'(active[0 +: DW]), FW'(32'h180));
`else
    check("collide_active0", FW'(active[0 +: DW]), FW'(32'h200));
`endif

    // out-of-range index
    wr(6, 32'hDEADBEEF, 4'hF);
    rd_idx = 3'd6;
    #1 check("rd_idx6_zero", FW'(rd_data), '0);
    rd_idx = 3'd7;
    #1 check("rd_idx7_zero", FW'(rd_data), '0);
    rd_idx = 3'd1;

    // assorted advances on a sane ring
    wr(0, 32'h100, 4'hF);
    wr(1, 32'h140, 4'hF);
    do_commit(1'b0);
    foreach (steps[i]) do_adv(steps[i]);
    @(negedge clk);

    // reset while a commit is pending
    do_commit(1'b1);
    rd_idx = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_active", active, '0);
    check("rst_ptr", FW'(ptr), '0);
    check("rst_pending", FW'(pending), '0);
    check("rst_done", FW'(done), '0);
    check("rst_wrap", FW'(wrap), '0);
    check("rst_rd", FW'(rd_data), '0);
    busy = 1'b0;
    done_cnt = 0; cnt_en = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 cnt_en = 0;
    check("rst_no_done", FW'(done_cnt), '0);

    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
